// File: rtl/order_entry_pkg.sv
// Shared definitions for the order-entry TX encoder and the market-data RX parser:
// frame geometry, side codes, byte offsets and the decoded order command.
package order_entry_pkg;

  localparam int unsigned FRAME_LEN  = 24;
  localparam int unsigned FRAME_BITS = (FRAME_LEN - 1) * 8;  // bytes 0..22; byte 23 is the checksum

  localparam logic [7:0] SIDE_BUY  = 8'h42;
  localparam logic [7:0] SIDE_SELL = 8'h53;

  localparam int unsigned OFS_START  = 0;
  localparam int unsigned OFS_TMPL   = 1;
  localparam int unsigned OFS_SEQ    = 2;
  localparam int unsigned OFS_SYMBOL = 6;
  localparam int unsigned OFS_PRICE  = 14;
  localparam int unsigned OFS_QTY    = 18;
  localparam int unsigned OFS_SIDE   = 22;
  localparam int unsigned OFS_CSUM   = 23;

  typedef struct packed {
    logic [63:0] symbol;
    logic [31:0] price;
    logic [31:0] qty;
    logic [7:0]  side;
  } order_cmd_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } enc_state_t;

  function automatic logic cmd_is_valid(input order_cmd_t c);
    return (c.qty != '0) && ((c.side == SIDE_BUY) || (c.side == SIDE_SELL));
  endfunction

endpackage

// File: rtl/order_frame_mux.sv
// Combinational byte selector over the latched frame; byte 0 sits in the MSBs and
// the final index returns the externally accumulated checksum.
module order_frame_mux
  import order_entry_pkg::*;
(
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [4:0]            idx,
  input  logic [7:0]            csum,
  output logic [7:0]            byte_out
);

  always_comb begin
    byte_out = '0;
    if (idx == 5'(OFS_CSUM)) begin
      byte_out = csum;
    end else begin
      for (int unsigned i = 0; i < FRAME_LEN - 1; i++) begin
        if (idx == 5'(i)) byte_out = frame[FRAME_BITS-1-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/order_entry_encoder.sv
// Serialises one validated order command into a 24-byte binary order frame on a
// valid/ready byte stream, stamping a sequence number and an XOR checksum.
module order_entry_encoder
  import order_entry_pkg::*;
#(
  parameter logic [7:0]  START_BYTE  = 8'hA5,
  parameter logic [7:0]  TEMPLATE_ID = 8'h01,
  parameter logic [31:0] SEQ_INIT    = 32'd1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] order_symbol,
  input  logic [31:0] order_price,
  input  logic [31:0] order_qty,
  input  logic [7:0]  order_side,
  input  logic        order_valid,
  output logic        order_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic [31:0] frame_count,
  output logic [31:0] reject_count,
  output logic [31:0] seq_num
);

  enc_state_t            state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q;
  logic [4:0]            idx_q;
  logic [7:0]            csum_q;
  logic [7:0]            mux_byte;
  order_cmd_t            cmd;
  logic                  load, reject, byte_ack, frame_done, last_byte;

  always_comb begin
    cmd.symbol = order_symbol;
    cmd.price  = order_price;
    cmd.qty    = order_qty;
    cmd.side   = order_side;
  end

  order_frame_mux u_mux (
    .frame    (frame_q),
    .idx      (idx_q),
    .csum     (csum_q),
    .byte_out (mux_byte)
  );

  assign last_byte = (idx_q == 5'(OFS_CSUM));

  always_comb begin
    state_d     = state_q;
    order_ready = 1'b0;
    tx_valid    = 1'b0;
    tx_last     = 1'b0;
    tx_data     = '0;
    busy        = 1'b0;
    load        = 1'b0;
    reject      = 1'b0;
    byte_ack    = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        order_ready = 1'b1;
        if (order_valid) begin
          if (cmd_is_valid(cmd)) begin
            load    = 1'b1;
            state_d = ST_SEND;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = mux_byte;
        tx_last  = last_byte;
        if (tx_ready) begin
          byte_ack = 1'b1;
          if (last_byte) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      frame_count  <= '0;
      reject_count <= '0;
      seq_num      <= SEQ_INIT;
    end else begin
      state_q <= state_d;
      if (load) begin
        frame_q <= {START_BYTE, TEMPLATE_ID, seq_num, cmd.symbol, cmd.price, cmd.qty, cmd.side};
        idx_q   <= '0;
        csum_q  <= '0;
      end
      if (reject) reject_count <= reject_count + 32'd1;
      if (byte_ack) begin
        idx_q <= idx_q + 5'd1;
        // Start byte is excluded from the checksum; it covers template through side.
        if ((idx_q >= 5'(OFS_TMPL)) && (idx_q <= 5'(OFS_SIDE))) csum_q <= csum_q ^ mux_byte;
      end
      if (frame_done) begin
        frame_count <= frame_count + 32'd1;
        seq_num     <= seq_num + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_order_entry_encoder.sv
// Scoreboard bench for order_entry_encoder: expected frame bytes are queued when a
// command is offered and compared as the encoder hands each byte over.
module tb_order_entry_encoder;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_byte_t;

  logic        clk;
  logic        rstn;
  logic [63:0] order_symbol;
  logic [31:0] order_price;
  logic [31:0] order_qty;
  logic [7:0]  order_side;
  logic        order_valid;
  logic        order_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic [31:0] frame_count;
  logic [31:0] reject_count;
  logic [31:0] seq_num;

  logic        w_order_valid, w_order_ready, w_tx_valid, w_tx_ready, w_tx_last, w_busy;
  logic [7:0]  w_tx_data;
  logic [31:0] w_frame_count, w_reject_count, w_seq_num;

  int          errors = 0;
  int          checks = 0;
  exp_byte_t   exp_q[$];
  logic        mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        prev_last = 1'b0;
  int          bytes_seen = 0;
  int          stall_checks = 0;
  int          rdy_mode = 0;
  int          bp_phase = 0;
  logic [31:0] model_seq = 32'd1;
  logic [31:0] exp_frames = 0;
  logic [31:0] exp_rejects = 0;

  order_entry_encoder #(.START_BYTE(8'hA5), .TEMPLATE_ID(8'h01), .SEQ_INIT(32'd1)) dut (
    .clk(clk), .rstn(rstn),
    .order_symbol(order_symbol), .order_price(order_price), .order_qty(order_qty),
    .order_side(order_side), .order_valid(order_valid), .order_ready(order_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .frame_count(frame_count), .reject_count(reject_count), .seq_num(seq_num)
  );

  order_entry_encoder #(.START_BYTE(8'hA5), .TEMPLATE_ID(8'h01), .SEQ_INIT(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rstn(rstn),
    .order_symbol(order_symbol), .order_price(order_price), .order_qty(order_qty),
    .order_side(order_side), .order_valid(w_order_valid), .order_ready(w_order_ready),
    .tx_data(w_tx_data), .tx_valid(w_tx_valid), .tx_ready(w_tx_ready), .tx_last(w_tx_last),
    .busy(w_busy), .frame_count(w_frame_count), .reject_count(w_reject_count), .seq_num(w_seq_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin
        tx_ready = (bp_phase == 0) || (bp_phase == 3);
        bp_phase = (bp_phase + 1) % 4;
      end
      2:       tx_ready = 1'b0;
      default: tx_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    exp_byte_t e;
    if (mon_en) begin
      if (prev_stall) begin
        checks++;
        stall_checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
          errors++;
          $display("FAIL stall_stable: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   tx_valid, tx_data, tx_last, prev_data, prev_last);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: data=%h last=%b, required no byte", tx_data, tx_last);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e.data || tx_last !== e.last) begin
            errors++;
            $display("FAIL frame_byte: data=%h last=%b, required data=%h last=%b",
                     tx_data, tx_last, e.data, e.last);
          end
        end
        bytes_seen++;
      end
      prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
      prev_data  = tx_data;
      prev_last  = tx_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic void push_frame(input logic [31:0] sq, input logic [63:0] sym,
                                     input logic [31:0] pr, input logic [31:0] qt,
                                     input logic [7:0] sd);
    logic [191:0] f;
    logic [7:0]   cs;
    exp_byte_t    e;
    f  = {8'hA5, 8'h01, sq, sym, pr, qt, sd, 8'h00};
    cs = 8'h00;
    for (int i = 1; i <= 22; i++) cs = cs ^ f[191-8*i -: 8];
    for (int i = 0; i < 24; i++) begin
      e.data = (i == 23) ? cs : f[191-8*i -: 8];
      e.last = (i == 23);
      exp_q.push_back(e);
    end
  endfunction

  task automatic send_order(input logic [63:0] sym, input logic [31:0] pr,
                            input logic [31:0] qt, input logic [7:0] sd);
    int n = 0;
    @(posedge clk); #1;
    order_symbol = sym; order_price = pr; order_qty = qt; order_side = sd;
    order_valid  = 1'b1;
    @(negedge clk);
    while (order_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: order_ready=%b, required 1 within 200 cycles", order_ready);
    end
    if (qt != 0 && (sd == 8'h42 || sd == 8'h53)) begin
      push_frame(model_seq, sym, pr, qt, sd);
      model_seq  = model_seq + 32'd1;
      exp_frames = exp_frames + 32'd1;
      bytes_seen = 0;
    end else begin
      exp_rejects = exp_rejects + 32'd1;
    end
    @(posedge clk); #1;
    order_valid  = 1'b0;
    order_symbol = {$urandom, $urandom};
    order_price  = $urandom;
    order_qty    = $urandom;
    order_side   = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes outstanding, busy=%b, required 0", exp_q.size(), busy);
    end
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    checks++;
    if (frame_count !== exp_frames || reject_count !== exp_rejects || seq_num !== model_seq) begin
      errors++;
      $display("FAIL counts_%s: frames=%0d rejects=%0d seq=%h, required frames=%0d rejects=%0d seq=%h",
               tag, frame_count, reject_count, seq_num, exp_frames, exp_rejects, model_seq);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (order_ready !== 1'b1 || tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00 ||
        busy !== 1'b0 || frame_count !== 32'd0 || reject_count !== 32'd0 || seq_num !== 32'd1) begin
      errors++;
      $display("FAIL %s: rdy=%b v=%b last=%b data=%h busy=%b fc=%0d rc=%0d seq=%h, required 1 0 0 00 0 0 0 00000001",
               tag, order_ready, tx_valid, tx_last, tx_data, busy, frame_count, reject_count, seq_num);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_values");
    @(posedge clk); #1;
    rstn   = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    rdy_mode = 0;
    send_order(64'h4553_5A35_0000_0000, 32'd450025, 32'd10, 8'h42);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_byte_latency: valid=%b data=%h busy=%b, required 1 a5 1", tx_valid, tx_data, busy);
    end
    wait_drain();
    check_counts("single");
  endtask

  task automatic test_backpressure();
    int s0;
    s0 = stall_checks;
    rdy_mode = 1;
    bp_phase = 0;
    send_order(64'h4553_5A35_0000_0000, 32'd450025, 32'd10, 8'h42);
    wait_drain();
    rdy_mode = 0;
    checks++;
    if (stall_checks - s0 < 10) begin
      errors++;
      $display("FAIL stall_coverage: %0d stalled cycles seen, required at least 10", stall_checks - s0);
    end
    check_counts("backpressure");
  endtask

  task automatic test_reject();
    send_order(64'h1111_2222_3333_4444, 32'd100, 32'd0, 8'h53);
    send_order(64'h1111_2222_3333_4444, 32'd100, 32'd5, 8'h58);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL reject_no_tx: tx_valid=%b, required 0", tx_valid);
      end
    end
    check_counts("reject");
  endtask

  task automatic test_back_to_back();
    logic [63:0] syms[3] = '{64'h4142_4344_4546_4748, 64'h0102_0304_0506_0708, 64'hFFEE_DDCC_BBAA_9988};
    logic [31:0] prs[3]  = '{32'd1, 32'hDEAD_BEEF, 32'd77};
    logic [31:0] qts[3]  = '{32'd3, 32'hFFFF_FFFF, 32'd1};
    logic [7:0]  sds[3]  = '{8'h42, 8'h53, 8'h42};
    int k = 0, cyc = 0, last_acc = 0;
    rdy_mode = 0;
    @(posedge clk); #1;
    order_symbol = syms[0]; order_price = prs[0]; order_qty = qts[0]; order_side = sds[0];
    order_valid  = 1'b1;
    while (k < 3 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (order_ready === 1'b1) begin
        push_frame(model_seq, syms[k], prs[k], qts[k], sds[k]);
        model_seq  = model_seq + 32'd1;
        exp_frames = exp_frames + 32'd1;
        if (k > 0) begin
          checks++;
          if (cyc - last_acc != 25) begin
            errors++;
            $display("FAIL b2b_period: %0d cycles between accepts, required 25", cyc - last_acc);
          end
        end
        last_acc = cyc;
        k++;
        @(posedge clk); #1;
        if (k < 3) begin
          order_symbol = syms[k]; order_price = prs[k]; order_qty = qts[k]; order_side = sds[k];
        end else begin
          order_valid = 1'b0;
        end
      end
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL b2b_accepts: %0d commands accepted, required 3", k);
    end
    order_valid = 1'b0;
    wait_drain();
    check_counts("b2b");
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    rdy_mode = 0;
    send_order(64'h5A5A_5A5A_A5A5_A5A5, 32'd999, 32'd42, 8'h53);
    while (bytes_seen < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    check_idle_outputs("reset_mid_frame");
    exp_q.delete();
    model_seq   = 32'd1;
    exp_frames  = 0;
    exp_rejects = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rstn   = 1'b1;
    mon_en = 1'b1;
    send_order(64'h0000_0000_0000_0001, 32'd5, 32'd6, 8'h42);
    wait_drain();
    check_counts("after_reset");
  endtask

  task automatic test_seq_wrap();
    logic [7:0]  fb[24];
    logic [7:0]  cs;
    logic [31:0] want;
    for (int f = 0; f < 2; f++) begin
      want = (f == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
      @(posedge clk); #1;
      order_symbol = 64'h5345_5121_0000_00FF; order_price = 32'd123; order_qty = 32'd9; order_side = 8'h53;
      w_order_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (w_order_ready !== 1'b1 || w_seq_num !== want) begin
        errors++;
        $display("FAIL wrap_ready_seq: ready=%b seq_num=%h, required 1 %h", w_order_ready, w_seq_num, want);
      end
      @(posedge clk); #1;
      w_order_valid = 1'b0;
      order_symbol  = '0;
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        fb[i] = w_tx_data;
        checks++;
        if (w_tx_valid !== 1'b1 || w_tx_last !== (i == 23)) begin
          errors++;
          $display("FAIL wrap_stream: byte %0d valid=%b last=%b, required valid=1 last=%b",
                   i, w_tx_valid, w_tx_last, (i == 23));
        end
      end
      checks++;
      if ({fb[2], fb[3], fb[4], fb[5]} !== want) begin
        errors++;
        $display("FAIL wrap_seq_field: %h, required %h", {fb[2], fb[3], fb[4], fb[5]}, want);
      end
      cs = 8'h00;
      for (int i = 1; i <= 22; i++) cs = cs ^ fb[i];
      checks++;
      if (fb[23] !== cs || fb[0] !== 8'hA5 || fb[22] !== 8'h53) begin
        errors++;
        $display("FAIL wrap_frame: start=%h side=%h csum=%h, required a5 53 %h", fb[0], fb[22], fb[23], cs);
      end
    end
    @(negedge clk);
    checks++;
    if (w_seq_num !== 32'd1 || w_frame_count !== 32'd2) begin
      errors++;
      $display("FAIL wrap_counters: seq_num=%h frames=%0d, required 00000001 2", w_seq_num, w_frame_count);
    end
  endtask

  initial begin
    rstn          = 1'b0;
    order_symbol  = '0;
    order_price   = '0;
    order_qty     = '0;
    order_side    = '0;
    order_valid   = 1'b0;
    tx_ready      = 1'b1;
    w_order_valid = 1'b0;
    w_tx_ready    = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_reject();
    test_back_to_back();
    test_reset_mid_frame();
    test_seq_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_bytes: %0d, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
